// File: rtl/ring_freq_meter.sv
// ring_freq_meter: multi-channel ring-oscillator frequency meter.
// Each asynchronous ring input is synchronised, edge-detected and counted over
// a fixed gate window of i_clk cycles. All channels snapshot together at the
// end of each window into hold registers. The first window after reset is
// discarded while the synchronisers settle.
// Ports:
//   i_clk   system clock, all state on its rising edge
//   i_rst   asynchronous active-high reset
//   i_ring  [pCHANNELS] ring oscillator outputs (asynchronous)
//   i_sel   [5:2] channel index, [1:0] byte index
//   o_LED   selected byte, registered
// Optional: define RING_FREQ_METER_GREY_EN to present bytes 0-2 as Gray code.
module ring_freq_meter #(
    parameter int unsigned pCHANNELS = 4,
    parameter int unsigned pGATE     = 1000,
    parameter int unsigned pCNT_W    = 16,
    parameter int unsigned pSYNC     = 2
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic [pCHANNELS-1:0] i_ring,
    input  logic [5:0]           i_sel,
    output logic [7:0]           o_LED
);

    localparam int unsigned GATE_W = $clog2(pGATE);
    localparam int unsigned SEQ_W  = 7;
    localparam int unsigned PAD_W  = 24;
    localparam logic [pCNT_W-1:0] CNT_MAX = '1;

    typedef enum logic {sWARM, sRUN} state_t;

    state_t state_q, state_d;
    logic   latch_c;

    logic [pSYNC-1:0][pCHANNELS-1:0] sync_q;
    logic [pCHANNELS-1:0]            prev_q;
    logic [pCHANNELS-1:0]            ring_edge_c;

    logic [GATE_W-1:0] gate_q;
    logic              term_c;

    logic [pCHANNELS-1:0][pCNT_W-1:0] cnt_q, cnt_nxt_c, hold_q;
    logic [pCHANNELS-1:0]             sat_q, sat_nxt_c, hold_sat_q;
    logic [SEQ_W-1:0]                 seq_q;

    logic [3:0] sel_ch_c;
    logic [1:0] sel_byte_c;
    logic [7:0] led_c;

    // Synchroniser chain and previous-value register for edge detection
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            sync_q <= '0;
            prev_q <= '0;
        end else begin
            sync_q[0] <= i_ring;
            for (int unsigned s = 1; s < pSYNC; s++) begin
                sync_q[s] <= sync_q[s-1];
            end
            prev_q <= sync_q[pSYNC-1];
        end
    end

    assign ring_edge_c = sync_q[pSYNC-1] & ~prev_q;

    // Free-running gate counter, 0..pGATE-1
    assign term_c = (gate_q == GATE_W'(pGATE - 1));

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            gate_q <= '0;
        end else if (term_c) begin
            gate_q <= '0;
        end else begin
            gate_q <= gate_q + GATE_W'(1);
        end
    end

    // Saturating next count, including the current cycle's edge
    always_comb begin
        cnt_nxt_c = cnt_q;
        sat_nxt_c = sat_q;
        for (int unsigned ch = 0; ch < pCHANNELS; ch++) begin
            if (ring_edge_c[ch]) begin
                if (cnt_q[ch] == CNT_MAX) begin
                    sat_nxt_c[ch] = 1'b1;
                end else begin
                    cnt_nxt_c[ch] = cnt_q[ch] + pCNT_W'(1);
                end
            end
        end
    end

    // FSM: discard the first window after reset, then latch every window
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= sWARM;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        latch_c = 1'b0;
        case (state_q)
            sWARM: begin
                if (term_c) begin
                    state_d = sRUN;
                end
            end
            sRUN: begin
                latch_c = term_c;
            end
            default: state_d = sWARM;
        endcase
    end

    // Edge counters, hold registers and window sequence number
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            cnt_q      <= '0;
            sat_q      <= '0;
            hold_q     <= '0;
            hold_sat_q <= '0;
            seq_q      <= '0;
        end else begin
            if (term_c) begin
                cnt_q <= '0;
                sat_q <= '0;
            end else begin
                cnt_q <= cnt_nxt_c;
                sat_q <= sat_nxt_c;
            end
            if (latch_c) begin
                hold_q     <= cnt_nxt_c;
                hold_sat_q <= sat_nxt_c;
                seq_q      <= seq_q + SEQ_W'(1);
            end
        end
    end

    // Output byte select; channels beyond pCHANNELS read as all ones
    assign sel_ch_c   = i_sel[5:2];
    assign sel_byte_c = i_sel[1:0];

    always_comb begin
        logic [PAD_W-1:0]  val;
        logic [pCNT_W-1:0] raw;
        led_c = 8'hFF;
        val   = '0;
        raw   = '0;
        for (int unsigned ch = 0; ch < pCHANNELS; ch++) begin
            if (sel_ch_c == 4'(ch)) begin
`ifdef RING_FREQ_METER_GREY_EN
                raw = hold_q[ch] ^ (hold_q[ch] >> 1);
`else
                raw = hold_q[ch];
`endif
                val = PAD_W'(raw);
                case (sel_byte_c)
                    2'd0:    led_c = val[7:0];
                    2'd1:    led_c = val[15:8];
                    2'd2:    led_c = val[23:16];
                    default: led_c = {hold_sat_q[ch], seq_q};
                endcase
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_LED <= 8'h00;
        end else begin
            o_LED <= led_c;
        end
    end

endmodule
